// File: rtl/zimbo_pkg.sv
// Shared encodings for the Zimbo memory arbiter: FSM states and grant identifiers.
package zimbo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/zimbo_rr_arb.sv
// Two-way grant selection between fetch and data ports: fixed data priority or
// round-robin using the last granted port.
module zimbo_rr_arb
  import zimbo_pkg::*;
#(
  parameter int unsigned DPRIO = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic take,
  output logic grant
);

  logic last_grant;

  always_comb begin
    grant = GNT_IF;
    if (d_req && !if_req)
      grant = GNT_D;
    else if (d_req && if_req)
      grant = (DPRIO != 0) ? GNT_D : ~last_grant;
  end

  // Reset to fetch so the first contended grant goes to the data port.
  always_ff @(posedge clock) begin
    if (reset)
      last_grant <= GNT_IF;
    else if (take)
      last_grant <= grant;
  end

endmodule

// File: rtl/zimbo_memarb.sv
// Two-port (fetch / load-store) memory arbiter with req/ack handshakes,
// wait-state support, bus timeout with error reporting and a saturating error count.
module zimbo_memarb
  import zimbo_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned DPRIO   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] addrm,
  output logic [DATA_W-1:0] wmdata,
  output logic              memrd_en,
  output logic              memwr_en,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] rmdata,
  output logic [7:0]        err_cnt
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic          gnt;
  logic          we;
  logic          grant;
  logic          take;
  logic          expired;
  logic [CW-1:0] wait_cnt;

  assign take = (state == ST_IDLE) && (if_req || d_req);
  // wait_cnt holds the number of elapsed no-ready cycles, so the last permitted
  // cycle is TIMEOUT-1; this keeps the strobe high exactly TIMEOUT cycles.
  assign expired = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  zimbo_rr_arb #(.DPRIO(DPRIO)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .take   (take),
    .grant  (grant)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt      <= GNT_IF;
      we       <= 1'b0;
      wait_cnt <= '0;
      addrm    <= '0;
      wmdata   <= '0;
      memrd_en <= 1'b0;
      memwr_en <= 1'b0;
      if_ack   <= 1'b0;
      if_rdata <= '0;
      if_err   <= 1'b0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            gnt      <= grant;
            we       <= (grant == GNT_D) && d_we;
            addrm    <= (grant == GNT_D) ? d_addr : if_addr;
            wmdata   <= (grant == GNT_D) ? d_wdata : '0;
            memrd_en <= !((grant == GNT_D) && d_we);
            memwr_en <= (grant == GNT_D) && d_we;
            wait_cnt <= '0;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ready || expired) begin
            memrd_en <= 1'b0;
            memwr_en <= 1'b0;
            state    <= ST_DONE;
            if (gnt == GNT_D) begin
              d_ack <= 1'b1;
              d_err <= !mem_ready;
              if (!mem_ready)
                d_rdata <= '0;
              else if (!we)
                d_rdata <= rmdata;
            end else begin
              if_ack   <= 1'b1;
              if_err   <= !mem_ready;
              if_rdata <= mem_ready ? rmdata : '0;
            end
            if (!mem_ready && err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zimbo_memarb.sv
// Directed self-checking bench for zimbo_memarb: a round-robin instance and a
// data-priority instance share all inputs.
module tb_zimbo_memarb;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [15:0] if_addr, d_addr, d_wdata, rmdata;

  logic        if_ack, if_err, d_ack, d_err, memrd_en, memwr_en;
  logic [15:0] if_rdata, d_rdata, addrm, wmdata;
  logic [7:0]  err_cnt;

  logic        p_if_ack, p_if_err, p_d_ack, p_d_err, p_memrd_en, p_memwr_en;
  logic [15:0] p_if_rdata, p_d_rdata, p_addrm, p_wmdata;
  logic [7:0]  p_err_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clock = ~clock;

  zimbo_memarb #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15), .DPRIO(0)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .addrm(addrm), .wmdata(wmdata), .memrd_en(memrd_en), .memwr_en(memwr_en),
    .mem_ready(mem_ready), .rmdata(rmdata), .err_cnt(err_cnt)
  );

  zimbo_memarb #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15), .DPRIO(1)) dut_p (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(p_if_ack), .if_rdata(p_if_rdata), .if_err(p_if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(p_d_ack), .d_rdata(p_d_rdata), .d_err(p_d_err),
    .addrm(p_addrm), .wmdata(p_wmdata), .memrd_en(p_memrd_en), .memwr_en(p_memwr_en),
    .mem_ready(mem_ready), .rmdata(rmdata), .err_cnt(p_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addrm"},  32'(addrm), 0);
    check({tag, "_wmdata"}, 32'(wmdata), 0);
    check({tag, "_strobe"}, 32'({memrd_en, memwr_en}), 0);
    check({tag, "_acks"},   32'({if_ack, d_ack}), 0);
    check({tag, "_errs"},   32'({if_err, d_err}), 0);
    check({tag, "_rdata"},  {if_rdata, d_rdata}, 0);
    check({tag, "_errcnt"}, 32'(err_cnt), 0);
  endtask

  // Raise one request, assert mem_ready on strobe cycle rdy_at (0 = never),
  // return strobe-cycle count and cycles until ack, then drop req.
  task automatic run_txn(input logic use_d, input int rdy_at, output int strobes, output int lat);
    logic got;
    got = 1'b0;
    strobes = 0;
    lat = 0;
    if (use_d) d_req = 1'b1; else if_req = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      lat++;
      if (if_ack || d_ack) got = 1'b1;
      else begin
        if (memrd_en || memwr_en) strobes++;
        mem_ready = (rdy_at != 0) && (strobes == rdy_at);
      end
    end
    if (!got) check("txn_ack_bound", 0, 1);
    if_req = 1'b0;
    d_req = 1'b0;
    mem_ready = 1'b0;
    step();
  endtask

  initial begin
    int s, l;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; rmdata = '0;
    step();
    step();
    check_all_zero("rst");
    reset = 1'b0;

    // Fetch, zero wait; mem_ready held high also in IDLE (must be ignored).
    if_req = 1'b1; if_addr = 16'h0040; mem_ready = 1'b1; rmdata = 16'hBEEF;
    step();
    check("f_c1_rd", 32'(memrd_en), 1);
    check("f_c1_wr", 32'(memwr_en), 0);
    check("f_c1_addr", 32'(addrm), 32'h0040);
    check("f_c1_ack", 32'(if_ack), 0);
    step();
    check("f_c2_ack", 32'(if_ack), 1);
    check("f_c2_rd", 32'(memrd_en), 0);
    check("f_c2_rdata", 32'(if_rdata), 32'hBEEF);
    check("f_c2_err", 32'(if_err), 0);
    check("f_c2_dack", 32'(d_ack), 0);
    if_req = 1'b0; mem_ready = 1'b0;
    step();
    check("f_c3_ack", 32'(if_ack), 0);

    // Store with three wait cycles.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'h5A5A; rmdata = 16'hDEAD;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("st_wr%0d", i), 32'({memwr_en, memrd_en}), 32'b10);
      check($sformatf("st_wd%0d", i), 32'(wmdata), 32'h5A5A);
      check($sformatf("st_ad%0d", i), 32'(addrm), 32'h1234);
      check($sformatf("st_ack%0d", i), 32'(d_ack), 0);
      if (i == 4) mem_ready = 1'b1;
    end
    step();
    check("st_ack", 32'(d_ack), 1);
    check("st_wr_off", 32'(memwr_en), 0);
    check("st_rdata_keep", 32'(d_rdata), 0);
    check("st_err", 32'(d_err), 0);
    check("st_if_hold", 32'(if_rdata), 32'hBEEF);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    step();

    // Both requests held: round-robin alternates D,IF,D,IF; priority always D.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0100; d_req = 1'b1; d_addr = 16'h0200; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      rmdata = 16'h1000 + 16'(k);
      step();
      check($sformatf("rr%0d_addr", k), 32'(addrm), exp_d ? 32'h0200 : 32'h0100);
      check($sformatf("pr%0d_addr", k), 32'(p_addrm), 32'h0200);
      step();
      check($sformatf("rr%0d_acks", k), 32'({d_ack, if_ack}), exp_d ? 32'b10 : 32'b01);
      check($sformatf("pr%0d_acks", k), 32'({p_d_ack, p_if_ack}), 32'b10);
      check($sformatf("rr%0d_rdata", k), 32'(exp_d ? d_rdata : if_rdata), 32'h1000 + k);
      step();
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;

    // Timeout after a successful fetch so rdata visibly clears.
    do_reset();
    rmdata = 16'hBEEF;
    run_txn(1'b0, 1, s, l);
    check("zw_strobes", 32'(s), 1);
    check("zw_lat", 32'(l), 2);
    check("zw_rdata", 32'(if_rdata), 32'hBEEF);
    if_addr = 16'h0040;
    run_txn(1'b0, 0, s, l);
    check("to_strobes", 32'(s), 15);
    check("to_lat", 32'(l), 16);
    check("to_err", 32'(if_err), 1);
    check("to_rdata", 32'(if_rdata), 0);
    check("to_errcnt", 32'(err_cnt), 1);

    // mem_ready on the last permitted cycle wins.
    rmdata = 16'hC0DE;
    run_txn(1'b1, 15, s, l);
    check("late_strobes", 32'(s), 15);
    check("late_err", 32'(d_err), 0);
    check("late_rdata", 32'(d_rdata), 32'hC0DE);
    check("late_errcnt", 32'(err_cnt), 1);

    for (int t = 0; t < 254; t++) run_txn(1'b0, 0, s, l);
    check("sat_255", 32'(err_cnt), 255);
    run_txn(1'b1, 0, s, l);
    check("sat_hold", 32'(err_cnt), 255);
    check("sat_derr", 32'(d_err), 1);
    check("sat_drdata", 32'(d_rdata), 0);

    // Reset in the middle of ACCESS.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0ABC; mem_ready = 1'b0;
    step();
    step();
    step();
    check("mid_rd", 32'(memrd_en), 1);
    reset = 1'b1;
    step();
    check_all_zero("mid_rst");
    d_req = 1'b0;
    step();
    check("mid_rst_ack", 32'({if_ack, d_ack}), 0);
    reset = 1'b0;
    rmdata = 16'h7777;
    run_txn(1'b0, 1, s, l);
    check("post_strobes", 32'(s), 1);
    check("post_lat", 32'(l), 2);
    check("post_rdata", 32'(if_rdata), 32'h7777);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
